// File: rtl/reg_check_pkg.sv
// Shared types and default configuration for the register check engine.
package reg_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_NUM_CHECKS = 8;
  localparam int DEF_IDX_W      = 3;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_AW     = 5;
  localparam int DEF_CYC_W      = 16;
  localparam int DEF_ERR_W      = 8;

  // Expectation entry layout at the default widths.
  typedef struct packed {
    logic                  en;
    logic [DEF_REG_AW-1:0] reg_num;
    logic [DEF_DATA_W-1:0] val;
  } chk_entry_t;

endpackage

// File: rtl/reg_check_table.sv
// Expectation table: one write port, one combinational read port.
// Only the enable bits are reset; register numbers and values are plain storage.
module reg_check_table #(
  parameter int NUM_CHECKS = 8,
  parameter int IDX_W      = 3,
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic              wr_en_i,
  input  logic [REG_AW-1:0] wr_reg_i,
  input  logic [DATA_W-1:0] wr_val_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_en_o,
  output logic [REG_AW-1:0] rd_reg_o,
  output logic [DATA_W-1:0] rd_val_o
);

  logic [NUM_CHECKS-1:0] en_q;
  logic [REG_AW-1:0]     reg_q [NUM_CHECKS];
  logic [DATA_W-1:0]     val_q [NUM_CHECKS];

  logic wr_ok;
  logic rd_ok;

  // Indices past the table end are dropped on write and read back as disabled.
  assign wr_ok = we_i && (int'(wr_idx_i) < NUM_CHECKS);
  assign rd_ok = int'(rd_idx_i) < NUM_CHECKS;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      en_q <= '0;
    end else if (wr_ok) begin
      en_q[wr_idx_i] <= wr_en_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (wr_ok) begin
      reg_q[wr_idx_i] <= wr_reg_i;
      val_q[wr_idx_i] <= wr_val_i;
    end
  end

  assign rd_en_o  = rd_ok && en_q[rd_idx_i];
  assign rd_reg_o = rd_ok ? reg_q[rd_idx_i] : '0;
  assign rd_val_o = rd_ok ? val_q[rd_idx_i] : '0;

endmodule

// File: rtl/reg_check_engine.sv
// Runs the processor for a programmed cycle count, then sweeps the expectation
// table through a spare regfile read port, counting and reporting mismatches.
//
// state | meaning
// IDLE  | waiting for start, table writable
// RUN   | processor enabled, counting cycles up to the latched limit
// CHECK | one table entry compared per cycle against chk_data
// DONE  | result held (done/pass), table writable, start reruns
module reg_check_engine
  import reg_check_pkg::*;
#(
  parameter int NUM_CHECKS = DEF_NUM_CHECKS,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_AW     = DEF_REG_AW,
  parameter int CYC_W      = DEF_CYC_W,
  parameter int ERR_W      = DEF_ERR_W
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [CYC_W-1:0]  cycle_limit_i,
  input  logic              exp_we_i,
  input  logic [IDX_W-1:0]  exp_idx_i,
  input  logic              exp_en_i,
  input  logic [REG_AW-1:0] exp_reg_i,
  input  logic [DATA_W-1:0] exp_val_i,
  output logic              proc_run_o,
  output logic [REG_AW-1:0] chk_reg_o,
  input  logic [DATA_W-1:0] chk_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ERR_W-1:0]  error_count_o,
  output logic              fail_valid_o,
  output logic [REG_AW-1:0] fail_reg_o,
  output logic [DATA_W-1:0] fail_exp_o,
  output logic [DATA_W-1:0] fail_got_o
);

  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHECKS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_e            state_q;
  logic [CYC_W-1:0]  lim_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ERR_W-1:0]  err_q;
  logic [ERR_W-1:0]  err_d;
  logic              proc_run_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              fail_valid_q;
  logic [REG_AW-1:0] fail_reg_q;
  logic [DATA_W-1:0] fail_exp_q;
  logic [DATA_W-1:0] fail_got_q;

  logic              tbl_we;
  logic              rd_en;
  logic [REG_AW-1:0] rd_reg;
  logic [DATA_W-1:0] rd_val;
  logic              mismatch;

  assign tbl_we = exp_we_i && ((state_q == IDLE) || (state_q == DONE));

  reg_check_table #(
    .NUM_CHECKS(NUM_CHECKS),
    .IDX_W     (IDX_W),
    .DATA_W    (DATA_W),
    .REG_AW    (REG_AW)
  ) u_table (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .we_i    (tbl_we),
    .wr_idx_i(exp_idx_i),
    .wr_en_i (exp_en_i),
    .wr_reg_i(exp_reg_i),
    .wr_val_i(exp_val_i),
    .rd_idx_i(idx_q),
    .rd_en_o (rd_en),
    .rd_reg_o(rd_reg),
    .rd_val_o(rd_val)
  );

  always_comb begin
    mismatch = (state_q == CHECK) && rd_en && (chk_data_i != rd_val);
    err_d    = err_q;
    if (mismatch && (err_q != ERR_MAX)) begin
      err_d = err_q + 1'b1;
    end
  end

  assign chk_reg_o = (state_q == CHECK) ? rd_reg : '0;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      lim_q        <= '0;
      cyc_q        <= '0;
      idx_q        <= '0;
      err_q        <= '0;
      proc_run_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_reg_q   <= '0;
      fail_exp_q   <= '0;
      fail_got_q   <= '0;
    end else begin
      fail_valid_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            lim_q      <= cycle_limit_i;
            cyc_q      <= '0;
            idx_q      <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_reg_q <= '0;
            fail_exp_q <= '0;
            fail_got_q <= '0;
            busy_q     <= 1'b1;
            // A zero limit skips RUN entirely.
            if (cycle_limit_i == '0) begin
              state_q    <= CHECK;
              proc_run_q <= 1'b0;
            end else begin
              state_q    <= RUN;
              proc_run_q <= 1'b1;
            end
          end
        end
        RUN: begin
          cyc_q <= cyc_q + 1'b1;
          if (cyc_q == lim_q - CYC_ONE) begin
            state_q    <= CHECK;
            idx_q      <= '0;
            proc_run_q <= 1'b0;
          end
        end
        CHECK: begin
          err_q <= err_d;
          if (mismatch) begin
            fail_valid_q <= 1'b1;
            fail_reg_q   <= rd_reg;
            fail_exp_q   <= rd_val;
            fail_got_q   <= chk_data_i;
          end
          if (idx_q == IDX_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign proc_run_o    = proc_run_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign error_count_o = err_q;
  assign fail_valid_o  = fail_valid_q;
  assign fail_reg_o    = fail_reg_q;
  assign fail_exp_o    = fail_exp_q;
  assign fail_got_o    = fail_got_q;

endmodule

// File: tb/tb_reg_check_engine.sv
// Bench for reg_check_engine: two instances (8-bit and 2-bit error counters)
// share stimulus; results are predicted from a table/regfile model.
module tb_reg_check_engine;
  import reg_check_pkg::*;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          start;
  logic [CW-1:0] cycle_limit;
  logic          exp_we;
  logic [IW-1:0] exp_idx;
  logic          exp_en;
  logic [AW-1:0] exp_reg;
  logic [DW-1:0] exp_val;

  logic          proc_run_a, busy_a, done_a, pass_a, fv_a;
  logic [AW-1:0] chk_reg_a, freg_a;
  logic [DW-1:0] chk_data_a, fexp_a, fgot_a;
  logic [7:0]    err_a;

  logic          proc_run_b, busy_b, done_b, pass_b, fv_b;
  logic [AW-1:0] chk_reg_b, freg_b;
  logic [DW-1:0] chk_data_b, fexp_b, fgot_b;
  logic [1:0]    err_b;

  logic [DW-1:0] rf [32];
  assign chk_data_a = rf[chk_reg_a];
  assign chk_data_b = rf[chk_reg_b];

  reg_check_engine #(.ERR_W(8)) u_dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .cycle_limit_i(cycle_limit),
    .exp_we_i(exp_we), .exp_idx_i(exp_idx), .exp_en_i(exp_en), .exp_reg_i(exp_reg),
    .exp_val_i(exp_val), .proc_run_o(proc_run_a), .chk_reg_o(chk_reg_a),
    .chk_data_i(chk_data_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .error_count_o(err_a), .fail_valid_o(fv_a), .fail_reg_o(freg_a),
    .fail_exp_o(fexp_a), .fail_got_o(fgot_a)
  );

  reg_check_engine #(.ERR_W(2)) u_sat (
    .clock_i(clock), .reset_i(reset), .start_i(start), .cycle_limit_i(cycle_limit),
    .exp_we_i(exp_we), .exp_idx_i(exp_idx), .exp_en_i(exp_en), .exp_reg_i(exp_reg),
    .exp_val_i(exp_val), .proc_run_o(proc_run_b), .chk_reg_o(chk_reg_b),
    .chk_data_i(chk_data_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .error_count_o(err_b), .fail_valid_o(fv_b), .fail_reg_o(freg_b),
    .fail_exp_o(fexp_b), .fail_got_o(fgot_b)
  );

  chk_entry_t m_tab [N];
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic int sat(input int n, input int m);
    return (n > m) ? m : n;
  endfunction

  task automatic write_entry(input int idx, input bit en, input logic [AW-1:0] r,
                             input logic [DW-1:0] v);
    exp_we = 1'b1; exp_idx = IW'(idx); exp_en = en; exp_reg = r; exp_val = v;
    tick();
    exp_we = 1'b0;
    m_tab[idx] = '{en: en, reg_num: r, val: v};
  endtask

  // Drives a write that will be sampled on the same edge as the next start.
  task automatic set_pending(input int idx, input bit en, input logic [AW-1:0] r,
                             input logic [DW-1:0] v);
    exp_we = 1'b1; exp_idx = IW'(idx); exp_en = en; exp_reg = r; exp_val = v;
    m_tab[idx] = '{en: en, reg_num: r, val: v};
  endtask

  task automatic do_run(input string tag, input int lim, input bit busy_wr);
    chk_entry_t    q[$];
    logic [DW-1:0] gots[$];
    chk_entry_t    e;
    logic [DW-1:0] g;
    logic [AW-1:0] want_reg;
    int nf, j, pr, pa, pb;
    for (int i = 0; i < N; i++) begin
      if (m_tab[i].en && (rf[m_tab[i].reg_num] !== m_tab[i].val)) begin
        q.push_back(m_tab[i]);
        gots.push_back(rf[m_tab[i].reg_num]);
      end
    end
    nf = q.size();
    start = 1'b1; cycle_limit = CW'(lim);
    tick();
    start = 1'b0; exp_we = 1'b0;
    check({tag, "/busy_at_start"}, 64'(busy_a), 64'(1));
    check({tag, "/err_cleared"}, 64'(err_a), 64'(0));
    check({tag, "/done_cleared"}, 64'(done_a), 64'(0));
    check({tag, "/fail_reg_cleared"}, 64'(freg_a), 64'(0));
    j = 0; pr = 0; pa = 0; pb = 0;
    forever begin
      want_reg = (j >= lim && j < lim + N) ? m_tab[j - lim].reg_num : '0;
      check({tag, "/chk_reg"}, 64'(chk_reg_a), 64'(want_reg));
      if (proc_run_a) pr++;
      if (fv_b) pb++;
      if (fv_a) begin
        pa++;
        if (q.size() > 0) begin
          e = q.pop_front();
          g = gots.pop_front();
          check({tag, "/fail_reg"}, 64'(freg_a), 64'(e.reg_num));
          check({tag, "/fail_exp"}, 64'(fexp_a), 64'(e.val));
          check({tag, "/fail_got"}, 64'(fgot_a), 64'(g));
        end
      end
      if (done_a || j >= 200) break;
      if (busy_wr && j == 1) begin
        exp_we = 1'b1; exp_idx = 3'd5; exp_en = 1'b1; exp_reg = 5'd9; exp_val = rf[9] ^ 32'h1;
      end
      if (j == 2) exp_we = 1'b0;
      tick();
      j++;
    end
    check({tag, "/latency"}, 64'(j), 64'(lim + N));
    check({tag, "/proc_run_cycles"}, 64'(pr), 64'(lim));
    check({tag, "/fail_pulses_a"}, 64'(pa), 64'(nf));
    check({tag, "/fail_pulses_b"}, 64'(pb), 64'(nf));
    check({tag, "/err_a"}, 64'(err_a), 64'(sat(nf, 255)));
    check({tag, "/err_b"}, 64'(err_b), 64'(sat(nf, 3)));
    check({tag, "/pass_a"}, 64'(pass_a), 64'(nf == 0));
    check({tag, "/pass_b"}, 64'(pass_b), 64'(nf == 0));
    check({tag, "/busy_done"}, 64'(busy_a), 64'(0));
    tick();
    check({tag, "/done_hold"}, 64'(done_a), 64'(j == lim + N));
    check({tag, "/fv_clear"}, 64'(fv_a), 64'(0));
  endtask

  initial begin
    logic [AW-1:0] r;
    int lim;
    reset = 1'b0; start = 1'b0; cycle_limit = '0; exp_we = 1'b0;
    exp_idx = '0; exp_en = 1'b0; exp_reg = '0; exp_val = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    for (int i = 0; i < N; i++) m_tab[i] = '0;
    repeat (3) tick();
    check("reset/busy", 64'(busy_a), 64'(0));
    check("reset/done", 64'(done_a), 64'(0));
    check("reset/pass", 64'(pass_a), 64'(0));
    check("reset/proc_run", 64'(proc_run_a), 64'(0));
    check("reset/err", 64'(err_a), 64'(0));
    check("reset/fail_valid", 64'(fv_a), 64'(0));
    check("reset/chk_reg", 64'(chk_reg_a), 64'(0));
    reset = 1'b1;
    tick();

    // single pass
    rf[1] = 32'd2;
    write_entry(0, 1'b1, 5'd1, 32'd2);
    do_run("single", 10, 1'b0);

    // mismatches, then rerun from DONE
    rf[3] = 32'h0000_000A; rf[7] = 32'h0;
    write_entry(0, 1'b0, 5'd1, 32'd2);
    write_entry(1, 1'b1, 5'd3, 32'h0000_000A);
    write_entry(2, 1'b1, 5'd7, 32'hFFFF_FFFF);
    do_run("mismatch", 4, 1'b0);
    do_run("rerun", 4, 1'b0);

    do_run("zero_limit", 0, 1'b0);

    // writes during RUN must be dropped
    do_run("busy_write", 6, 1'b1);
    do_run("busy_verify", 3, 1'b0);

    // write and start on the same edge
    set_pending(5, 1'b1, 5'd9, rf[9] ^ 32'h1);
    do_run("same_edge", 2, 1'b0);

    // saturation: every entry mismatches
    for (int i = 0; i < N; i++) write_entry(i, 1'b1, AW'(i + 10), rf[i + 10] ^ 32'h8000_0000);
    do_run("saturate", 1, 1'b0);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      for (int i = 0; i < N; i++) begin
        r = AW'($urandom_range(31, 0));
        write_entry(i, 1'($urandom_range(1, 0)), r, ($urandom_range(1, 0) != 0) ? rf[r] : $urandom);
      end
      lim = $urandom_range(15, 0);
      do_run("random", lim, 1'b0);
    end

    // reset in the middle of CHECK
    write_entry(0, 1'b1, 5'd4, rf[4] ^ 32'h1);
    write_entry(1, 1'b1, 5'd6, rf[6] ^ 32'h2);
    for (int i = 2; i < N; i++) write_entry(i, 1'b0, 5'd0, 32'd0);
    start = 1'b1; cycle_limit = 16'd2;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("midcheck/busy", 64'(busy_a), 64'(1));
    check("midcheck/err", 64'(err_a), 64'(2));
    reset = 1'b0;
    tick();
    check("rst_mid/busy", 64'(busy_a), 64'(0));
    check("rst_mid/done", 64'(done_a), 64'(0));
    check("rst_mid/err", 64'(err_a), 64'(0));
    check("rst_mid/fail_reg", 64'(freg_a), 64'(0));
    check("rst_mid/fail_exp", 64'(fexp_a), 64'(0));
    check("rst_mid/fail_got", 64'(fgot_a), 64'(0));
    check("rst_mid/chk_reg", 64'(chk_reg_a), 64'(0));
    check("rst_mid/proc_run", 64'(proc_run_a), 64'(0));
    reset = 1'b1;
    for (int i = 0; i < N; i++) m_tab[i].en = 1'b0;
    tick();
    do_run("after_reset", 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_check_engine.md
Name: reg_check_engine

Overview:
- Synthesizable, parametrised successor to the processor self-test harness.
- Lets the processor run for a programmable number of cycles, then sweeps a table of expected register values through a regfile read port.
- Counts mismatches, reports each failure, and raises done/pass.
- Sits beside the skeleton: the processor enable is gated by proc_run, and a spare regfile read port is muxed in through chk_reg/chk_data.

Parameters:
- NUM_CHECKS, 8: entries in the expectation table.
- IDX_W, 3: table index width; must satisfy 2^IDX_W >= NUM_CHECKS.
- DATA_W, 32: register data width.
- REG_AW, 5: register address width.
- CYC_W, 16: width of the cycle limit and cycle counter.
- ERR_W, 8: error counter width.

Ports:
- clock, in, 1: system clock, rising edge.
- reset, in, 1: synchronous, active-low reset.
- start, in, 1: begin a run; sampled in IDLE or DONE.
- cycle_limit, in, CYC_W: number of processor cycles to run; latched on start.
- exp_we, in, 1: write one expectation entry.
- exp_idx, in, IDX_W: entry index to write.
- exp_en, in, 1: entry valid; 0 means the entry is skipped.
- exp_reg, in, REG_AW: register number to check.
- exp_val, in, DATA_W: expected register value.
- proc_run, out, 1: processor enable; high only in RUN.
- chk_reg, out, REG_AW: regfile read address.
- chk_data, in, DATA_W: regfile read data, combinational, same cycle as chk_reg.
- busy, out, 1: high in RUN or CHECK.
- done, out, 1: high in DONE.
- pass, out, 1: done and error_count == 0.
- error_count, out, ERR_W: number of mismatches, saturating.
- fail_valid, out, 1: one-cycle pulse per mismatch.
- fail_reg, out, REG_AW: register number of the mismatch.
- fail_exp, out, DATA_W: expected value of the mismatch.
- fail_got, out, DATA_W: value read at the mismatch.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - state = IDLE; all outputs 0; cycle counter and index cleared.
  - All table entries get exp_en = 0; exp_reg and exp_val are not reset.
  - Reset overrides everything, including mid-RUN and mid-CHECK.
- States: IDLE, RUN, CHECK, DONE.
- IDLE / DONE:
  - exp_we writes table[exp_idx]; exp_idx >= NUM_CHECKS is ignored.
  - start = 1:
    - latch cycle_limit;
    - clear error_count, done and the fail_* outputs;
    - cyc = 0;
    - go to RUN.
  - If exp_we and start arrive on the same edge, the write happens first and the new entry is used.
  - start with cycle_limit = 0 goes directly to CHECK (zero RUN cycles).
- RUN:
  - proc_run = 1; cyc increments each cycle.
  - When cyc == limit-1, go to CHECK with idx = 0; proc_run is therefore high for exactly `limit` cycles.
  - start and exp_we are ignored.
- CHECK:
  - One entry per cycle: chk_reg = table[idx].reg, and chk_data is compared in the same cycle.
  - If entry enabled and chk_data != table[idx].val:
    - error_count += 1, saturating at 2^ERR_W - 1;
    - next cycle: fail_valid = 1 and fail_reg/exp/got hold the registered mismatch.
  - fail_* outputs hold their last values; fail_valid deasserts unless another mismatch occurs.
  - Disabled entries take a cycle but never fail.
  - At idx == NUM_CHECKS-1, go to DONE.
  - start and exp_we are ignored.
- Idle chk_reg: when not in CHECK, chk_reg = 0.
- DONE:
  - done = 1; pass = (error_count == 0); holds until start or reset.
- Timing:
  - Latency from start edge to done = limit + NUM_CHECKS cycles (plus 0 for limit = 0).
  - The last fail_valid can coincide with the first DONE cycle.

Decomposition:
- Package reg_check_pkg:
  - state enum (IDLE = 2'd0, RUN = 2'd1, CHECK = 2'd2, DONE = 2'd3);
  - default parameter constants;
  - a table entry struct {en, reg, val}.
- Sub-module: reg_check_table, NUM_CHECKS-entry register array with one write port and one combinational read port.
- FSM, counters and compare logic stay in the top module.

Test Plan:
- Single pass:
  - Table[0] = {en 1, reg 1, val 2}, all other entries disabled; regfile model returns 2 for r1.
  - start with cycle_limit 10 → proc_run high exactly 10 cycles, done 18 cycles after start, pass = 1, error_count = 0, no fail_valid.
- Mismatches:
  - Entries r3 = 0x0000000A and r7 = 0xFFFFFFFF; model returns r3 = 0x0000000A, r7 = 0.
  - → exactly one fail_valid with fail_reg = 7, fail_exp = FFFFFFFF, fail_got = 0; error_count = 1; pass = 0.
- Saturation: ERR_W = 2, all 8 entries mismatched → error_count stops at 3, fail_valid pulses 8 times.
- Zero limit and busy writes:
  - cycle_limit = 0 → proc_run never asserts; CHECK starts on the next cycle.
  - exp_we issued during RUN → table unchanged; verified by a rerun.
- Reset and restart:
  - reset low in the middle of CHECK → next cycle IDLE, all outputs 0, table entries disabled.
  - start from DONE → error_count cleared and the run repeats.
